apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 13 +
 rtl/counter_ld.sv | 24 ++
 rtl/apb_master.sv | 148 ++++++++++++++
 tb/tb_apb_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB initiator and its helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/counter_ld.sv
// Loadable up-counter that saturates at all-ones instead of wrapping.
module counter_ld #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // A load has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: turns a single-outstanding command/response handshake into
// SETUP/ACCESS transfers, with wait-state handling and a wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen on the last permitted pready=0 cycle.
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic             cmd_accept;
    logic             xfer_done;
    logic             xfer_timeout;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state_q == IDLE);

    counter_ld #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk   (pclk),
        .rst_n (presetn),
        .load  (cnt_load),
        .d     ('0),
        .en    (cnt_en),
        .q     (wait_cnt)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A ready response on the would-be timeout cycle completes normally.
    always_comb begin
        state_d      = state_q;
        cmd_accept   = 1'b0;
        xfer_done    = 1'b0;
        xfer_timeout = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cnt_load = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    xfer_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (wait_cnt == LAST_WAIT)) begin
                        xfer_timeout = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus control flops follow the next state so they change with the FSM.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
        end else begin
            psel    <= (state_d != IDLE);
            penable <= (state_d == ACCESS);
            busy    <= (state_d != IDLE);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (cmd_accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
        end
    end

    // Response fields hold until the next completion overwrites them.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= xfer_done | xfer_timeout;
            if (xfer_done) begin
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (xfer_timeout) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed, table-driven bench for apb_master acting as its APB responder.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prd;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    vec_t vecs[6];

    apb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transfer; the bench plays the responder with v.waits wait states.
    task automatic run_xfer(input vec_t v);
        int  acc;
        bit  done;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        check_output("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_wdata = 32'h0;
        check_output("setup_psel", 32'(psel), 32'd1);
        check_output("setup_penable", 32'(penable), 32'd0);
        check_output("setup_busy", 32'(busy), 32'd1);
        check_output("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("setup_pwrite", 32'(pwrite), 32'(v.wr));
        check_output("setup_paddr", paddr, v.addr);
        pready  = 1'b1;
        pslverr = 1'b1;
        @(negedge pclk);
        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (psel && penable) begin
                acc++;
                check_output("access_paddr", paddr, v.addr);
                check_output("access_rsp_valid", 32'(rsp_valid), 32'd0);
                if (v.wr) check_output("access_pwdata", pwdata, v.wdata);
                if (acc > v.waits) begin
                    pready  = 1'b1;
                    prdata  = v.prd;
                    pslverr = v.slverr;
                end else begin
                    pready  = 1'b0;
                    prdata  = 32'h0BAD_0BAD;
                    pslverr = ~v.slverr;
                end
                @(negedge pclk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check_output("xfer_bound", 32'd0, 32'd1);
        pready  = 1'b0;
        pslverr = 1'b0;
        check_output("access_cycles", 32'(acc), 32'(v.exp_acc));
        check_output("rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("rsp_rdata", rsp_rdata, v.exp_rdata);
        check_output("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        check_output("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
        check_output("done_psel", 32'(psel), 32'd0);
        check_output("done_busy", 32'(busy), 32'd0);
        check_output("done_cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("done_paddr_kept", paddr, v.addr);
        if (v.wr) check_output("done_pwdata_kept", pwdata, v.wdata);
        @(negedge pclk);
        check_output("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check_output("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
        check_output("rsp_err_hold", 32'(rsp_err), 32'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] pat;
        logic [31:0] addrs[3];
        int          pulses;
        int          n;

        //           wr    addr          wdata         waits prd           err   exp_rdata     e_err e_to acc
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h1DCD_6500, 0,   32'h1111_2222, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         3,   32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b1, 32'h0000_0C00, 32'hDEAD_BEEF, 0,   32'h1234_5678, 1'b1, 32'h0,        1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         100, 32'hCAFE_0000, 1'b0, 32'h0,        1'b1, 1'b1, 16};
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         15,  32'h0000_0F0F, 1'b0, 32'h0000_0F0F, 1'b0, 1'b0, 16};
        vecs[5] = '{1'b0, 32'h0000_0014, 32'h0,         2,   32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 3};

        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(negedge pclk);
        check_output("rst_psel", 32'(psel), 32'd0);
        check_output("rst_penable", 32'(penable), 32'd0);
        check_output("rst_pwrite", 32'(pwrite), 32'd0);
        check_output("rst_paddr", paddr, 32'd0);
        check_output("rst_pwdata", pwdata, 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_output("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        presetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i]);
        end

        // Held cmd_valid: three reads accepted every third cycle.
        addrs[0] = 32'h0000_0020;
        addrs[1] = 32'h0000_0024;
        addrs[2] = 32'h0000_0028;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addrs[0];
        pready    = 1'b1;
        prdata    = 32'h0000_0077;
        pat       = '0;
        pulses    = 0;
        n         = 0;
        for (int c = 0; c < 11; c++) begin
            pat[c] = psel;
            if (rsp_valid) pulses++;
            if (psel && !penable) begin
                if (n < 3) check_output("b2b_paddr", paddr, addrs[n]);
                n++;
                if (n < 3) cmd_addr = addrs[n];
                else cmd_valid = 1'b0;
            end
            @(negedge pclk);
        end
        pready = 1'b0;
        check_output("b2b_psel_pattern", 32'(pat), 32'(11'b00110110110));
        check_output("b2b_rsp_pulses", 32'(pulses), 32'd3);
        check_output("b2b_accepts", 32'(n), 32'd3);
        check_output("b2b_last_rdata", rsp_rdata, 32'h0000_0077);

        // Reset pulled in the second ACCESS cycle of a stalled read.
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0030;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check_output("rst_mid_acc1", 32'(penable), 32'd1);
        @(negedge pclk);
        check_output("rst_mid_acc2", 32'(penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check_output("rst_mid_psel", 32'(psel), 32'd0);
        check_output("rst_mid_penable", 32'(penable), 32'd0);
        check_output("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) begin
            @(negedge pclk);
            check_output("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        presetn = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            check_output("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            check_output("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        run_xfer(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
